// File: rtl/apsk_frame_scheduler.sv
// Per-frame sequencer for the APSK modulator: a fixed-length header packet, then a payload
// packet. Modulator controls are only retargeted while the modulator is drained.
module apsk_frame_scheduler #(
  parameter int unsigned DATA_WIDTH            = 32,
  parameter int unsigned HEADER_WORDS          = 3,
  parameter int unsigned HEADER_BPS            = 1,
  parameter int unsigned BITS_PER_SYMBOL_WIDTH = 4,
  parameter int unsigned LENGTH_WIDTH          = 16
) (
  input  logic                             aclk,
  input  logic                             reset,
  input  logic [31:0]                      descriptor_tdata,
  input  logic                             descriptor_tvalid,
  output logic                             descriptor_tready,
  input  logic [DATA_WIDTH-1:0]            header_in_tdata,
  input  logic                             header_in_tvalid,
  output logic                             header_in_tready,
  input  logic [DATA_WIDTH-1:0]            payload_in_tdata,
  input  logic                             payload_in_tlast,
  input  logic                             payload_in_tvalid,
  output logic                             payload_in_tready,
  output logic [DATA_WIDTH-1:0]            mod_tdata,
  output logic                             mod_tlast,
  output logic                             mod_tvalid,
  input  logic                             mod_tready,
  input  logic                             mod_done,
  output logic [BITS_PER_SYMBOL_WIDTH-1:0] bits_per_symbol,
  output logic                             offset_symbol_enable,
  output logic                             busy,
  output logic                             err_short,
  output logic                             err_long,
  output logic                             err_desc,
  output logic [15:0]                      frame_count
);
  localparam int unsigned HDR_CNT_W = 8;
  localparam int unsigned BPSW      = BITS_PER_SYMBOL_WIDTH;
  localparam logic [BPSW-1:0]      HDR_BPS  = BPSW'(HEADER_BPS);
  localparam logic [HDR_CNT_W-1:0] HDR_LAST = HDR_CNT_W'(HEADER_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, HEADER, WAIT_HDR, PAYLOAD, DISCARD, WAIT_PAY
  } state_t;

  state_t                  state_q, state_d;
  logic [HDR_CNT_W-1:0]    hdr_cnt_q, hdr_cnt_d;
  logic [LENGTH_WIDTH-1:0] pay_cnt_q, pay_cnt_d;
  logic [LENGTH_WIDTH-1:0] len_q, len_d;
  logic [BPSW-1:0]         pbps_q, pbps_d;
  logic                    pofs_q, pofs_d;
  logic [BPSW-1:0]         bps_q, bps_d;
  logic                    ofs_q, ofs_d;
  logic                    err_short_q, err_short_d;
  logic                    err_long_q, err_long_d;
  logic                    err_desc_q, err_desc_d;
  logic [15:0]             frame_count_q, frame_count_d;
  logic                    done_flag_q, done_flag_d;

  logic [3:0]  desc_bps;
  logic        desc_ofs;
  logic [15:0] desc_len;
  logic        desc_bad;
  logic        pay_at_len;
  logic        unused_desc_bits;

  assign desc_bps   = descriptor_tdata[27:24];
  assign desc_ofs   = descriptor_tdata[20];
  assign desc_len   = descriptor_tdata[15:0];
  assign desc_bad   = (desc_bps == 4'd0) || (desc_bps > 4'd8) || (desc_len == 16'd0);
  assign pay_at_len = (pay_cnt_q == (len_q - LENGTH_WIDTH'(1)));
  assign unused_desc_bits = ^{descriptor_tdata[31:28], descriptor_tdata[23:21],
                              descriptor_tdata[19:16]};

  // Next-state and zero-latency stream steering
  always_comb begin
    state_d           = state_q;
    hdr_cnt_d         = hdr_cnt_q;
    pay_cnt_d         = pay_cnt_q;
    len_d             = len_q;
    pbps_d            = pbps_q;
    pofs_d            = pofs_q;
    bps_d             = bps_q;
    ofs_d             = ofs_q;
    err_short_d       = err_short_q;
    err_long_d        = err_long_q;
    err_desc_d        = err_desc_q;
    frame_count_d     = frame_count_q;
    done_flag_d       = done_flag_q;
    descriptor_tready = 1'b0;
    header_in_tready  = 1'b0;
    payload_in_tready = 1'b0;
    mod_tdata         = '0;
    mod_tlast         = 1'b0;
    mod_tvalid        = 1'b0;

    case (state_q)
      IDLE: begin
        descriptor_tready = 1'b1;
        if (descriptor_tvalid) begin
          if (desc_bad) begin
            err_desc_d = 1'b1;
          end else begin
            pbps_d    = BPSW'(desc_bps);
            pofs_d    = desc_ofs;
            len_d     = LENGTH_WIDTH'(desc_len);
            bps_d     = HDR_BPS;
            ofs_d     = 1'b0;
            hdr_cnt_d = '0;
            state_d   = HEADER;
          end
        end
      end
      HEADER: begin
        mod_tdata        = header_in_tdata;
        mod_tvalid       = header_in_tvalid;
        mod_tlast        = (hdr_cnt_q == HDR_LAST);
        header_in_tready = mod_tready;
        if (header_in_tvalid && mod_tready) begin
          hdr_cnt_d = hdr_cnt_q + HDR_CNT_W'(1);
          if (hdr_cnt_q == HDR_LAST) begin
            state_d = WAIT_HDR;
          end
        end
      end
      WAIT_HDR: begin
        if (mod_done) begin
          bps_d     = pbps_q;
          ofs_d     = pofs_q;
          pay_cnt_d = '0;
          state_d   = PAYLOAD;
        end
      end
      PAYLOAD: begin
        mod_tdata         = payload_in_tdata;
        mod_tvalid        = payload_in_tvalid;
        mod_tlast         = payload_in_tlast || pay_at_len;
        payload_in_tready = mod_tready;
        if (payload_in_tvalid && mod_tready) begin
          pay_cnt_d = pay_cnt_q + LENGTH_WIDTH'(1);
          if (pay_at_len) begin
            if (!payload_in_tlast) begin
              err_long_d = 1'b1;
              state_d    = DISCARD;
            end else begin
              state_d = WAIT_PAY;
            end
          end else if (payload_in_tlast) begin
            err_short_d = 1'b1;
            state_d     = WAIT_PAY;
          end
        end
      end
      DISCARD: begin
        // The modulator may finish the truncated segment before the source ends its packet
        payload_in_tready = 1'b1;
        if (mod_done) begin
          done_flag_d = 1'b1;
        end
        if (payload_in_tvalid && payload_in_tlast) begin
          state_d = WAIT_PAY;
        end
      end
      WAIT_PAY: begin
        if (mod_done || done_flag_q) begin
          frame_count_d = frame_count_q + 16'd1;
          bps_d         = HDR_BPS;
          ofs_d         = 1'b0;
          done_flag_d   = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (reset) begin
      descriptor_tready = 1'b0;
      header_in_tready  = 1'b0;
      payload_in_tready = 1'b0;
      mod_tvalid        = 1'b0;
    end
  end

  // State and control registers
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q       <= IDLE;
      hdr_cnt_q     <= '0;
      pay_cnt_q     <= '0;
      len_q         <= '0;
      pbps_q        <= '0;
      pofs_q        <= 1'b0;
      bps_q         <= HDR_BPS;
      ofs_q         <= 1'b0;
      err_short_q   <= 1'b0;
      err_long_q    <= 1'b0;
      err_desc_q    <= 1'b0;
      frame_count_q <= '0;
      done_flag_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hdr_cnt_q     <= hdr_cnt_d;
      pay_cnt_q     <= pay_cnt_d;
      len_q         <= len_d;
      pbps_q        <= pbps_d;
      pofs_q        <= pofs_d;
      bps_q         <= bps_d;
      ofs_q         <= ofs_d;
      err_short_q   <= err_short_d;
      err_long_q    <= err_long_d;
      err_desc_q    <= err_desc_d;
      frame_count_q <= frame_count_d;
      done_flag_q   <= done_flag_d;
    end
  end

  assign bits_per_symbol      = bps_q;
  assign offset_symbol_enable = ofs_q;
  assign busy                 = (state_q != IDLE);
  assign err_short            = err_short_q;
  assign err_long             = err_long_q;
  assign err_desc             = err_desc_q;
  assign frame_count          = frame_count_q;

endmodule
